// File: rtl/single_cycle_cpu.sv
// rtl/single_cycle_cpu.sv - single-cycle MIPS subset CPU: PC, IM, GPR, ALU, DM
// Define CPU_TRACE_EN to print pc/instr and every GPR/DM write on each retiring edge.

module sc_imem #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clock,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic [AW-1:0] addr,
   output logic [31:0]   instr
);
   logic [31:0] ins_memory [0:DEPTH-1];

   always_ff @(posedge clock) begin
      if (wr_en) ins_memory[wr_addr] <= wr_data;
   end

   assign instr = ins_memory[addr];
endmodule

module sc_gpr (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);
   logic [31:0] gp_registers [0:31];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) gp_registers[i] <= 32'h0;
      end else if (we && wa != 5'd0) begin
         gp_registers[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? 32'h0 : gp_registers[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'h0 : gp_registers[ra2];
endmodule

module sc_dmem #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wd,
   output logic [31:0]   rd
);
   logic [31:0] data_memory [0:DEPTH-1];

   always_ff @(posedge clock) begin
      if (we) data_memory[addr] <= wd;
   end

   assign rd = data_memory[addr];
endmodule

module single_cycle_cpu #(
   parameter int          IM_DEPTH = 1024,
   parameter int          DM_DEPTH = 1024,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input logic clock,
   input logic reset
);
   localparam int IAW = $clog2(IM_DEPTH);
   localparam int DAW = $clog2(DM_DEPTH);

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
   localparam logic [5:0] OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LUI = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23, OP_SW  = 6'h2B;
   localparam logic [5:0] FN_JR  = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND = 6'h24, FN_OR   = 6'h25, FN_SLT  = 6'h2A;

   logic [31:0] pc, pc_plus4, beq_pc, npc, instr;
   logic [31:0] rs_data, rt_data, imm_sext, imm_zext, mem_addr, dm_rdata, wb_data;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, dest;
   logic [15:0] imm;
   logic [1:0]  s_npc;
   logic        reg_write, mem_write;
   logic        unused_addr_bits;

   assign opcode   = instr[31:26];
   assign rs       = instr[25:21];
   assign rt       = instr[20:16];
   assign rd       = instr[15:11];
   assign funct    = instr[5:0];
   assign imm      = instr[15:0];
   assign imm_sext = {{16{imm[15]}}, imm};
   assign imm_zext = {16'h0, imm};
   assign pc_plus4 = pc + 32'd4;
   assign beq_pc   = pc_plus4 + {imm_sext[29:0], 2'b00};
   assign mem_addr = rs_data + imm_sext;

   assign unused_addr_bits = ^{mem_addr[31:DAW+2], mem_addr[1:0]};

   sc_imem #(.DEPTH(IM_DEPTH), .AW(IAW)) IM (
      .clock   (clock),
      .wr_en   (1'b0),
      .wr_addr ({IAW{1'b0}}),
      .wr_data (32'h0),
      .addr    (pc[IAW+1:2]),
      .instr   (instr)
   );

   sc_gpr GPR (
      .clock (clock),
      .reset (reset),
      .ra1   (rs),
      .ra2   (rt),
      .rd1   (rs_data),
      .rd2   (rt_data),
      .we    (reg_write),
      .wa    (dest),
      .wd    (wb_data)
   );

   // Reset gates the store so a write in flight when reset rises is dropped.
   sc_dmem #(.DEPTH(DM_DEPTH), .AW(DAW)) DM (
      .clock (clock),
      .we    (mem_write & ~reset),
      .addr  (mem_addr[DAW+1:2]),
      .wd    (rt_data),
      .rd    (dm_rdata)
   );

   always_comb begin
      reg_write = 1'b0;
      mem_write = 1'b0;
      dest      = rt;
      wb_data   = 32'h0;
      s_npc     = 2'd0;
      case (opcode)
         OP_RTYPE: begin
            dest = rd;
            case (funct)
               FN_ADDU: begin reg_write = 1'b1; wb_data = rs_data + rt_data; end
               FN_SUBU: begin reg_write = 1'b1; wb_data = rs_data - rt_data; end
               FN_AND:  begin reg_write = 1'b1; wb_data = rs_data & rt_data; end
               FN_OR:   begin reg_write = 1'b1; wb_data = rs_data | rt_data; end
               FN_SLT:  begin
                  reg_write = 1'b1;
                  wb_data   = {31'h0, $signed(rs_data) < $signed(rt_data)};
               end
               FN_JR:   s_npc = 2'd3;
               default: ;
            endcase
         end
         OP_ADDIU: begin reg_write = 1'b1; wb_data = rs_data + imm_sext; end
         OP_ORI:   begin reg_write = 1'b1; wb_data = rs_data | imm_zext; end
         OP_LUI:   begin reg_write = 1'b1; wb_data = {imm, 16'h0}; end
         OP_LW:    begin reg_write = 1'b1; wb_data = dm_rdata; end
         OP_SW:    mem_write = 1'b1;
         OP_BEQ:   if (rs_data == rt_data) s_npc = 2'd1;
         OP_J:     s_npc = 2'd2;
         OP_JAL:   begin s_npc = 2'd2; reg_write = 1'b1; dest = 5'd31; wb_data = pc_plus4; end
         default:  ;
      endcase
   end

   always_comb begin
      case (s_npc)
         2'd1:    npc = beq_pc;
         2'd2:    npc = {pc_plus4[31:28], instr[25:0], 2'b00};
         2'd3:    npc = rs_data;
         default: npc = pc_plus4;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) pc <= RESET_PC;
      else       pc <= npc;
   end

`ifdef CPU_TRACE_EN
   always @(posedge clock) begin
      if (!reset) begin
         $display("pc=%08h instr=%08h", pc, instr);
         if (reg_write && dest != 5'd0) $display("  gpr[%0d] <= %08h", dest, wb_data);
         if (mem_write) $display("  dm[%08h] <= %08h", mem_addr, rt_data);
      end
   end
`else
`endif
endmodule

// File: tb/tb_single_cycle_cpu.sv
// tb/tb_single_cycle_cpu.sv - vector table, corner sequences and random programs vs an ISA model
module tb_single_cycle_cpu;
   logic clock = 1'b0;
   logic reset = 1'b1;

   single_cycle_cpu dut (.clock(clock), .reset(reset));

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   logic [31:0] prog_mem [0:1023];
   logic [31:0] m_regs   [0:31];
   logic [31:0] m_mem    [0:1023];
   logic [31:0] m_pc;

   typedef struct {
      string       name;
      logic [31:0] code [5];
      int          cycles;
      logic [4:0]  reg_idx;
      logic [31:0] reg_exp;
      logic [31:0] pc_exp;
   } vec_t;
   vec_t vq[$];

   function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input logic [5:0] fn);
      return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
   endfunction
   function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input logic [15:0] im);
      return {op, rs[4:0], rt[4:0], im};
   endfunction
   function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] idx);
      return {op, idx};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic check_regs(input string name);
      int first = -1;
      for (int i = 0; i < 32; i++)
         if (first < 0 && dut.GPR.gp_registers[i] !== m_regs[i]) first = i;
      total++;
      if (first >= 0) begin
         bad++;
         $display("FAIL %s: gpr[%0d] got %08h expected %08h", name, first,
                  dut.GPR.gp_registers[first], m_regs[first]);
      end
   endtask

   // Architectural interpreter: one instruction per call, straight from the ISA rules.
   task automatic model_step();
      logic [31:0] ins, a, b, se, npc, wv, addr;
      logic [4:0]  wr;
      logic        we;
      ins  = prog_mem[m_pc[11:2]];
      a    = m_regs[ins[25:21]];
      b    = m_regs[ins[20:16]];
      se   = {{16{ins[15]}}, ins[15:0]};
      addr = a + se;
      npc  = m_pc + 32'd4;
      we   = 1'b0;
      wr   = ins[20:16];
      wv   = 32'h0;
      case (ins[31:26])
         6'h00: begin
            wr = ins[15:11];
            case (ins[5:0])
               6'h21: begin we = 1'b1; wv = a + b; end
               6'h23: begin we = 1'b1; wv = a - b; end
               6'h24: begin we = 1'b1; wv = a & b; end
               6'h25: begin we = 1'b1; wv = a | b; end
               6'h2A: begin we = 1'b1; wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
               6'h08: npc = a;
               default: ;
            endcase
         end
         6'h09: begin we = 1'b1; wv = a + se; end
         6'h0D: begin we = 1'b1; wv = a | {16'h0, ins[15:0]}; end
         6'h0F: begin we = 1'b1; wv = {ins[15:0], 16'h0}; end
         6'h23: begin we = 1'b1; wv = m_mem[addr[11:2]]; end
         6'h2B: m_mem[addr[11:2]] = b;
         6'h04: if (a == b) npc = m_pc + 32'd4 + (se << 2);
         6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
         6'h03: begin we = 1'b1; wr = 5'd31; wv = m_pc + 32'd4; npc = {npc[31:28], ins[25:0], 2'b00}; end
         default: ;
      endcase
      if (we && wr != 5'd0) m_regs[wr] = wv;
      m_pc = npc;
   endtask

   task automatic load_and_hold_reset();
      reset = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         dut.IM.ins_memory[i]  = prog_mem[i];
         dut.DM.data_memory[i] = 32'h0;
         m_mem[i] = 32'h0;
      end
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_pc = 32'h0000_3000;
      @(negedge clock);
      @(negedge clock);
   endtask

   task automatic release_reset();
      reset = 1'b0;
      #1;
   endtask

   task automatic step();
      @(posedge clock);
      model_step();
      @(negedge clock);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 1024; i++) prog_mem[i] = 32'h0;
   endtask

   task automatic add_vec(input string n, input int cyc, input int r, input logic [31:0] e,
                          input logic [31:0] p, input logic [31:0] c0, input logic [31:0] c1 = 0,
                          input logic [31:0] c2 = 0, input logic [31:0] c3 = 0, input logic [31:0] c4 = 0);
      vec_t v;
      v.name = n; v.cycles = cyc; v.reg_idx = r[4:0]; v.reg_exp = e; v.pc_exp = p;
      v.code[0] = c0; v.code[1] = c1; v.code[2] = c2; v.code[3] = c3; v.code[4] = c4;
      vq.push_back(v);
   endtask

   function automatic logic [31:0] rand_instr();
      int rs = $urandom_range(0, 7);
      int rt = $urandom_range(0, 7);
      int rd = $urandom_range(0, 7);
      logic [15:0] im = 16'($urandom);
      case ($urandom_range(0, 11))
         0:  return r_ins(rs, rt, rd, 6'h21);
         1:  return r_ins(rs, rt, rd, 6'h23);
         2:  return r_ins(rs, rt, rd, 6'h2A);
         3:  return r_ins(rs, rt, rd, 6'h24);
         4:  return r_ins(rs, rt, rd, 6'h25);
         5:  return i_ins(6'h09, rs, rt, im);
         6:  return i_ins(6'h0D, rs, rt, im);
         7:  return i_ins(6'h0F, rs, rt, im);
         8:  return i_ins(6'h23, rs, rt, im);
         9:  return i_ins(6'h2B, rs, rt, im);
         10: return i_ins(6'h04, rs, rt, 16'($urandom_range(0, 3)));
         default: return {6'h3F, 26'($urandom)};
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] jmp_prog [5];
      jmp_prog[0] = j_ins(6'h02, 26'h0C02);
      jmp_prog[1] = r_ins(31, 0, 0, 6'h08);
      jmp_prog[2] = 32'h0;
      jmp_prog[3] = 32'h0;
      jmp_prog[4] = j_ins(6'h03, 26'h0C01);

      add_vec("ori", 1, 1, 32'h0000_1234, 32'h3004, i_ins(6'h0D, 0, 1, 16'h1234));
      add_vec("lui", 1, 2, 32'hABCD_0000, 32'h3004, i_ins(6'h0F, 0, 2, 16'hABCD));
      add_vec("addu", 3, 3, 32'hABCD_1234, 32'h300C, i_ins(6'h0D, 0, 1, 16'h1234),
              i_ins(6'h0F, 0, 2, 16'hABCD), r_ins(1, 2, 3, 6'h21));
      add_vec("sw_lw", 3, 4, 32'd5, 32'h300C, i_ins(6'h0D, 0, 1, 16'd5),
              i_ins(6'h2B, 0, 1, 16'd8), i_ins(6'h23, 0, 4, 16'd8));
      add_vec("zero_reg", 1, 0, 32'h0, 32'h3004, i_ins(6'h0D, 0, 0, 16'd7));
      add_vec("beq_taken", 1, 0, 32'h0, 32'h300C, i_ins(6'h04, 0, 0, 16'd2));
      add_vec("beq_not", 2, 1, 32'd1, 32'h3008, i_ins(6'h0D, 0, 1, 16'd1), i_ins(6'h04, 1, 0, 16'd2));
      add_vec("subu_wrap", 2, 3, 32'hFFFF_FFFF, 32'h3008, i_ins(6'h0D, 0, 1, 16'd1), r_ins(0, 1, 3, 6'h23));
      add_vec("slt_neg", 3, 5, 32'd1, 32'h300C, i_ins(6'h09, 0, 6, 16'hFFFF),
              i_ins(6'h0D, 0, 7, 16'd1), r_ins(6, 7, 5, 6'h2A));
      add_vec("slt_rev", 4, 5, 32'd0, 32'h3010, i_ins(6'h09, 0, 6, 16'hFFFF),
              i_ins(6'h0D, 0, 7, 16'd1), i_ins(6'h0D, 0, 5, 16'd9), r_ins(7, 6, 5, 6'h2A));
      add_vec("and", 3, 3, 32'h0000_0F00, 32'h300C, i_ins(6'h0D, 0, 1, 16'hFF0F),
              i_ins(6'h0D, 0, 2, 16'h0FF0), r_ins(1, 2, 3, 6'h24));
      add_vec("or", 3, 3, 32'h0000_FFFF, 32'h300C, i_ins(6'h0D, 0, 1, 16'hFF0F),
              i_ins(6'h0D, 0, 2, 16'h0FF0), r_ins(1, 2, 3, 6'h25));
      add_vec("addiu_sext", 1, 1, 32'hFFFF_8000, 32'h3004, i_ins(6'h09, 0, 1, 16'h8000));
      add_vec("ori_zext", 1, 2, 32'h0000_8000, 32'h3004, i_ins(6'h0D, 0, 2, 16'h8000));
      add_vec("neg_offset", 3, 2, 32'h0000_0010, 32'h300C, i_ins(6'h0D, 0, 1, 16'h0010),
              i_ins(6'h2B, 1, 1, 16'hFFFC), i_ins(6'h23, 0, 2, 16'h000C));
      add_vec("rd_before_wr", 2, 1, 32'd6, 32'h3008, i_ins(6'h0D, 0, 1, 16'd3), r_ins(1, 1, 1, 6'h21));
      add_vec("bad_funct_nop", 2, 2, 32'h0, 32'h3008, i_ins(6'h0D, 0, 1, 16'd3), r_ins(1, 1, 2, 6'h20));
      add_vec("bad_op_nop", 1, 2, 32'h0, 32'h3004, 32'hFC22_0005);
      add_vec("jal", 4, 31, 32'h0000_3014, 32'h3004, jmp_prog[0], jmp_prog[1], jmp_prog[2], jmp_prog[3], jmp_prog[4]);
      add_vec("jr", 5, 31, 32'h0000_3014, 32'h3014, jmp_prog[0], jmp_prog[1], jmp_prog[2], jmp_prog[3], jmp_prog[4]);

      // Reset state and first retirement.
      clear_prog();
      prog_mem[0] = i_ins(6'h0D, 0, 1, 16'h1234);
      load_and_hold_reset();
      check("reset_pc", dut.pc, 32'h0000_3000);
      check_regs("reset_gprs");
      release_reset();
      check("released_pc", dut.pc, 32'h0000_3000);
      step();
      check("first_edge_pc", dut.pc, 32'h0000_3004);

      foreach (vq[k]) begin
         clear_prog();
         for (int i = 0; i < 5; i++) prog_mem[i] = vq[k].code[i];
         load_and_hold_reset();
         release_reset();
         repeat (vq[k].cycles) step();
         check({vq[k].name, "_reg"}, dut.GPR.gp_registers[vq[k].reg_idx], vq[k].reg_exp);
         check({vq[k].name, "_pc"}, dut.pc, vq[k].pc_exp);
      end

      // Next-PC select and branch target, sampled before the retiring edge.
      clear_prog();
      prog_mem[0] = i_ins(6'h04, 0, 0, 16'd2);
      load_and_hold_reset();
      release_reset();
      check("beq_s_npc", {30'h0, dut.s_npc}, 32'd1);
      check("beq_pc", dut.beq_pc, 32'h0000_300C);

      clear_prog();
      prog_mem[0] = i_ins(6'h0D, 0, 1, 16'd1);
      prog_mem[1] = i_ins(6'h04, 1, 0, 16'd2);
      load_and_hold_reset();
      release_reset();
      step();
      check("beq_not_s_npc", {30'h0, dut.s_npc}, 32'd0);

      clear_prog();
      for (int i = 0; i < 5; i++) prog_mem[i] = jmp_prog[i];
      load_and_hold_reset();
      release_reset();
      repeat (4) step();
      check("jr_s_npc", {30'h0, dut.s_npc}, 32'd3);

      // Asynchronous reset mid-program: GPRs clear, DM keeps its contents, pending write dropped.
      clear_prog();
      prog_mem[0] = i_ins(6'h0D, 0, 1, 16'd5);
      prog_mem[1] = i_ins(6'h2B, 0, 1, 16'd8);
      prog_mem[2] = i_ins(6'h0D, 0, 2, 16'd9);
      load_and_hold_reset();
      release_reset();
      repeat (3) step();
      check_regs("pre_reset_gprs");
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_pc = 32'h0000_3000;
      check("async_reset_pc", dut.pc, 32'h0000_3000);
      check_regs("async_reset_gprs");
      check("dm_kept", dut.DM.data_memory[2], 32'd5);
      @(negedge clock);
      check("held_write_dropped", dut.GPR.gp_registers[1], 32'h0);
      check("held_pc", dut.pc, 32'h0000_3000);
      release_reset();
      step();
      check("resume_reg", dut.GPR.gp_registers[1], 32'd5);
      check("resume_pc", dut.pc, 32'h0000_3004);

      // Random straight-line programs with short forward branches.
      for (int p = 0; p < 4; p++) begin
         clear_prog();
         for (int i = 0; i < 48; i++) prog_mem[i] = rand_instr();
         load_and_hold_reset();
         release_reset();
         for (int c = 0; c < 60; c++) begin
            step();
            check($sformatf("rand%0d_pc_c%0d", p, c), dut.pc, m_pc);
            check_regs($sformatf("rand%0d_gpr_c%0d", p, c));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
